// File: rtl/eco32f_fetch_pkg.sv
// Shared definitions for the eco32f fetch stage.
//   - reset PC and nop encoding
//   - fetch FSM state encodings
//   - exception flag bundle and fetched-item record
//   - helper that builds a nop bubble for a given PC
package eco32f_fetch_pkg;

   localparam logic [31:0] ECO32F_RESET_PC = 32'he0000000;
   localparam logic [31:0] ECO32F_INSN_NOP = 32'h00000000;

   typedef enum logic [2:0] {
      ECO32F_FETCH_IDLE  = 3'd0,
      ECO32F_FETCH_REQ   = 3'd1,
      ECO32F_FETCH_DROP  = 3'd2,
      ECO32F_FETCH_HOLD  = 3'd3,
      ECO32F_FETCH_FAULT = 3'd4
   } fetch_state_e;

   typedef struct packed {
      logic ibus_fault;
      logic itlb_kmiss;
      logic itlb_umiss;
      logic itlb_invalid;
      logic itlb_priv;
   } fetch_exc_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      fetch_exc_t  exc;
   } fetch_item_t;

   function automatic fetch_item_t bubble_item(input logic [31:0] pc);
      fetch_item_t item;
      item.pc   = pc;
      item.insn = ECO32F_INSN_NOP;
      item.exc  = '0;
      return item;
   endfunction

endpackage

// File: rtl/eco32f_fetch_skid.sv
// One-entry skid buffer holding a fetched item while decode is stalled.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load, item_d  capture item_d (buffer must be empty)
//   unload        mark the entry consumed
//   clear         discard the entry (highest priority)
//   item_q, full  stored entry and its valid flag
module eco32f_fetch_skid
   import eco32f_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        unload,
   input  logic        clear,
   input  fetch_item_t item_d,
   output fetch_item_t item_q,
   output logic        full
);

   fetch_item_t entry_d, entry_q;
   logic        full_d, full_q;

   always_comb begin
      entry_d = entry_q;
      full_d  = full_q;
      if (clear) begin
         full_d = 1'b0;
      end else if (load) begin
         entry_d = item_d;
         full_d  = 1'b1;
      end else if (unload) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entry_q <= bubble_item(ECO32F_RESET_PC);
         full_q  <= 1'b0;
      end else begin
         entry_q <= entry_d;
         full_q  <= full_d;
      end
   end

   assign item_q = entry_q;
   assign full   = full_q;

endmodule

// File: rtl/eco32f_fetch.sv
// eco32f instruction fetch stage: owns the PC and the instruction bus
// master and delivers registered id_* to decode.
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   id_stall                hold id_* and do not accept a new instruction
//   redirect, redirect_pc   branch/exception redirect pulse and target
//   ibus_*                  instruction bus master (req/adr out, ack/err/dat in)
//   itlb_*                  TLB result for ibus_adr
//   id_pc, id_insn, id_exc_* instruction and fetch exceptions for decode
// Optional: define ECO32F_FETCH_TIMEOUT_EN to add a bus-ack watchdog that
// terminates a request as a bus error after TIMEOUT_CYCLES idle cycles.
module eco32f_fetch
   import eco32f_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = ECO32F_RESET_PC,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        ibus_req,
   output logic [31:0] ibus_adr,
   input  logic        ibus_ack,
   input  logic        ibus_err,
   input  logic [31:0] ibus_dat,
   input  logic        itlb_kmiss,
   input  logic        itlb_umiss,
   input  logic        itlb_invalid,
   input  logic        itlb_priv,
   output logic [31:0] id_pc,
   output logic [31:0] id_insn,
   output logic        id_exc_ibus_fault,
   output logic        id_exc_itlb_kmiss,
   output logic        id_exc_itlb_umiss,
   output logic        id_exc_itlb_invalid,
   output logic        id_exc_itlb_priv
);

   fetch_state_e state_d, state_q;
   logic [31:0]  pc_d, pc_q;
   logic [31:0]  adr_d, adr_q;
   logic         req_d, req_q;
   fetch_item_t  id_d, id_q;

   logic         tlb_hit, timeout, fault_term, term, fetch_valid;
   fetch_item_t  fetched, skid_item;
   logic         skid_load, skid_unload, skid_full;

`ifdef ECO32F_FETCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_d, to_cnt_q;

   // Watchdog: counts unterminated cycles of an outstanding request.
   always_comb begin
      to_cnt_d = '0;
      if (req_q && !term && !redirect)
         to_cnt_d = to_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) to_cnt_q <= '0;
      else      to_cnt_q <= to_cnt_d;
   end

   assign timeout = req_q && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
`else
   assign timeout = 1'b0;
`endif

   // Termination of the outstanding request; TLB flags end it without an ack.
   always_comb begin
      tlb_hit    = itlb_kmiss | itlb_umiss | itlb_invalid | itlb_priv;
      fault_term = tlb_hit | ibus_err | timeout;
      term       = req_q & (fault_term | ibus_ack);

      // Only one exception flag survives: TLB flags first, then bus fault.
      fetched.pc               = adr_q;
      fetched.insn             = fault_term ? ECO32F_INSN_NOP : ibus_dat;
      fetched.exc              = '0;
      fetched.exc.itlb_kmiss   = itlb_kmiss;
      fetched.exc.itlb_umiss   = !itlb_kmiss && itlb_umiss;
      fetched.exc.itlb_invalid = !itlb_kmiss && !itlb_umiss && itlb_invalid;
      fetched.exc.itlb_priv    = !itlb_kmiss && !itlb_umiss && !itlb_invalid && itlb_priv;
      fetched.exc.ibus_fault   = !tlb_hit && (ibus_err || timeout);

      fetch_valid = (state_q == ECO32F_FETCH_REQ) && term && !redirect;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ECO32F_FETCH_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic; a redirect overrides everything except a pending
   // unterminated request, which must be drained through DROP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ECO32F_FETCH_IDLE: state_d = ECO32F_FETCH_REQ;
         ECO32F_FETCH_REQ: begin
            if (redirect)
               state_d = term ? ECO32F_FETCH_REQ : ECO32F_FETCH_DROP;
            else if (term && fault_term)
               state_d = ECO32F_FETCH_FAULT;
            else if (term && id_stall)
               state_d = ECO32F_FETCH_HOLD;
         end
         ECO32F_FETCH_DROP: begin
            if (term) state_d = ECO32F_FETCH_REQ;
         end
         ECO32F_FETCH_HOLD: begin
            if (redirect || !id_stall) state_d = ECO32F_FETCH_REQ;
         end
         ECO32F_FETCH_FAULT: begin
            if (redirect) state_d = ECO32F_FETCH_REQ;
         end
         default: state_d = ECO32F_FETCH_IDLE;
      endcase
   end

   // Datapath: PC, bus address/request, skid control and id_* update.
   // The bus address only moves when a new request is launched, so it
   // stays stable during DROP while pc already holds the redirect target.
   always_comb begin
      pc_d = pc_q;
      if (redirect)
         pc_d = redirect_pc & ~32'h3;
      else if (fetch_valid && !fault_term)
         pc_d = pc_q + 32'd4;

      req_d = (state_d == ECO32F_FETCH_REQ) || (state_d == ECO32F_FETCH_DROP);
      adr_d = (state_d == ECO32F_FETCH_REQ) ? pc_d : adr_q;

      skid_load   = fetch_valid && id_stall;
      skid_unload = skid_full && !id_stall && !redirect;

      id_d = id_q;
      if (redirect)
         id_d = bubble_item(pc_q);
      else if (!id_stall) begin
         if (fetch_valid)    id_d = fetched;
         else if (skid_full) id_d = skid_item;
         else                id_d = bubble_item(pc_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q  <= RESET_PC;
         adr_q <= RESET_PC;
         req_q <= 1'b0;
         id_q  <= bubble_item(RESET_PC);
      end else begin
         pc_q  <= pc_d;
         adr_q <= adr_d;
         req_q <= req_d;
         id_q  <= id_d;
      end
   end

   eco32f_fetch_skid u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (skid_load),
      .unload (skid_unload),
      .clear  (redirect),
      .item_d (fetched),
      .item_q (skid_item),
      .full   (skid_full)
   );

   assign ibus_req            = req_q;
   assign ibus_adr            = adr_q;
   assign id_pc               = id_q.pc;
   assign id_insn             = id_q.insn;
   assign id_exc_ibus_fault   = id_q.exc.ibus_fault;
   assign id_exc_itlb_kmiss   = id_q.exc.itlb_kmiss;
   assign id_exc_itlb_umiss   = id_q.exc.itlb_umiss;
   assign id_exc_itlb_invalid = id_q.exc.itlb_invalid;
   assign id_exc_itlb_priv    = id_q.exc.itlb_priv;

endmodule
